// File: rtl/adder_seq_ctrl_if.sv
// Operand/result handshake bundle for adder_seq_ctrl.
// The cout wire exists only when ADDER_SEQ_CARRY_OUT_EN is defined.
interface adder_seq_ctrl_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             busy;
`ifdef ADDER_SEQ_CARRY_OUT_EN
    logic             cout;

    // Producer/consumer side drives operands and accepts results.
    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, busy, cout
    );

    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, busy, cout
    );
`else
    // Producer/consumer side drives operands and accepts results.
    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, busy
    );

    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, busy
    );
`endif
endinterface

// File: rtl/adder_seq_ctrl.sv
// Multi-cycle WIDTH-bit adder built from one shared SLICE-bit slice, carry chained
// across cycles. Define ADDER_SEQ_CARRY_OUT_EN to expose the final carry on cout.
module adder_seq_ctrl #(
    parameter int WIDTH = 32,
    parameter int SLICE = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    adder_seq_ctrl_if.slave bus
);
    localparam int NSLICE = WIDTH / SLICE;
    localparam int KW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(NSLICE - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] sum_r;
    logic [KW-1:0]    k_r;
    logic             carry_r;
    logic             in_ready_r;
    logic             out_valid_r;
    logic             busy_r;
`ifdef ADDER_SEQ_CARRY_OUT_EN
    logic             cout_r;
`endif

    logic [SLICE-1:0] slice_a_s;
    logic [SLICE-1:0] slice_b_s;
    logic [SLICE:0]   slice_sum_s;

    // Single shared slice adder: operand slices are selected by k_r via a shift mux.
    always_comb begin
        slice_a_s   = SLICE'(a_r >> (int'(k_r) * SLICE));
        slice_b_s   = SLICE'(b_r >> (int'(k_r) * SLICE));
        slice_sum_s = {1'b0, slice_a_s} + {1'b0, slice_b_s} + {{SLICE{1'b0}}, carry_r};
    end

    // Sequencer FSM; all handshake outputs and the result are registered here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            a_r         <= {WIDTH{1'b0}};
            b_r         <= {WIDTH{1'b0}};
            sum_r       <= {WIDTH{1'b0}};
            k_r         <= {KW{1'b0}};
            carry_r     <= 1'b0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
`ifdef ADDER_SEQ_CARRY_OUT_EN
            cout_r      <= 1'b0;
`endif
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.in_valid && in_ready_r) begin
                        a_r        <= bus.a;
                        b_r        <= bus.b;
                        carry_r    <= bus.cin;
                        k_r        <= {KW{1'b0}};
                        sum_r      <= {WIDTH{1'b0}};
                        in_ready_r <= 1'b0;
                        busy_r     <= 1'b1;
                        state_r    <= ST_RUN;
`ifdef ADDER_SEQ_CARRY_OUT_EN
                        cout_r     <= 1'b0;
`endif
                    end
                end

                ST_RUN: begin
                    for (int i = 0; i < NSLICE; i++) begin
                        if (k_r == KW'(i)) begin
                            sum_r[i*SLICE +: SLICE] <= slice_sum_s[SLICE-1:0];
                        end
                    end
                    carry_r <= slice_sum_s[SLICE];
                    // Last slice: wrap the counter explicitly so NSLICE=1 never overflows k.
                    if (k_r == K_LAST) begin
                        k_r         <= {KW{1'b0}};
                        out_valid_r <= 1'b1;
                        state_r     <= ST_DONE;
`ifdef ADDER_SEQ_CARRY_OUT_EN
                        cout_r      <= slice_sum_s[SLICE];
`endif
                    end else begin
                        k_r <= k_r + KW'(1);
                    end
                end

                ST_DONE: begin
                    if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        busy_r      <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state_r     <= ST_IDLE;
                    end
                end

                default: begin
                    state_r     <= ST_IDLE;
                    k_r         <= {KW{1'b0}};
                    in_ready_r  <= 1'b1;
                    out_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.sum       = sum_r;
    assign bus.busy      = busy_r;
`ifdef ADDER_SEQ_CARRY_OUT_EN
    assign bus.cout      = cout_r;
`endif

endmodule

// File: tb/tb_adder_seq_ctrl.sv
// Directed + randomized bench for adder_seq_ctrl at WIDTH=32 and WIDTH=8 (NSLICE=1),
// checked against plain-arithmetic sums. cout checks follow ADDER_SEQ_CARRY_OUT_EN.
module tb_adder_seq_ctrl;
    localparam int W  = 32;
    localparam int W8 = 8;

    logic clk = 1'b0;
    logic rst_n;
    int unsigned cyc = 0;
    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    adder_seq_ctrl_if #(.WIDTH(W))  bus  ();
    adder_seq_ctrl_if #(.WIDTH(W8)) bus8 ();

    adder_seq_ctrl #(.WIDTH(W), .SLICE(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    adder_seq_ctrl #(.WIDTH(W8), .SLICE(8)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus8)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W:0] ref_add32(input logic [W-1:0] x, input logic [W-1:0] y,
                                             input logic c);
        return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
    endfunction

    // Present operands, wait for in_ready, let one edge accept them, then scramble inputs.
    task automatic accept32(input logic [W-1:0] x, input logic [W-1:0] y, input logic c,
                            output int acc_cyc);
        int w;
        w = 0;
        bus.a = x;
        bus.b = y;
        bus.cin = c;
        bus.in_valid = 1'b1;
        while (!bus.in_ready && w < 20) begin
            tick();
            w++;
        end
        if (w >= 20) check("in_ready_timeout", {63'd0, bus.in_ready}, 64'd1);
        tick();
        acc_cyc = cyc;
        bus.in_valid = 1'b0;
        bus.a = $urandom;
        bus.b = $urandom;
        bus.cin = 1'($urandom_range(0, 1));
        check("busy_after_accept", {63'd0, bus.busy}, 64'd1);
        check("in_ready_after_accept", {63'd0, bus.in_ready}, 64'd0);
    endtask

    // Count edges until out_valid rises, checking busy stays high meanwhile.
    task automatic wait_out32(output int lat);
        lat = 0;
        while (!bus.out_valid && lat < 20) begin
            check("busy_in_run", {63'd0, bus.busy}, 64'd1);
            tick();
            lat++;
        end
    endtask

    initial begin
        int acc;
        int prev;
        int lat;
        logic [W:0]    e;
        logic [W-1:0]  x;
        logic [W-1:0]  y;
        logic          c;
        logic [W8:0]   e8;
        logic [W8-1:0] x8;
        logic [W8-1:0] y8;

        rst_n = 1'b0;
        bus.in_valid = 1'b0;  bus.a = 32'd0; bus.b = 32'd0; bus.cin = 1'b0; bus.out_ready = 1'b0;
        bus8.in_valid = 1'b0; bus8.a = 8'd0; bus8.b = 8'd0; bus8.cin = 1'b0; bus8.out_ready = 1'b0;

        // Reset state
        #12;
        check("rst_in_ready", {63'd0, bus.in_ready}, 64'd1);
        check("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
        check("rst_busy", {63'd0, bus.busy}, 64'd0);
        check("rst_sum", {32'd0, bus.sum}, 64'd0);
        check("rst8_in_ready", {63'd0, bus8.in_ready}, 64'd1);
        check("rst8_sum", {56'd0, bus8.sum}, 64'd0);
`ifdef ADDER_SEQ_CARRY_OUT_EN
        check("rst_cout", {63'd0, bus.cout}, 64'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Wrap-around
        accept32(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, acc);
        wait_out32(lat);
        check("wrap_latency", 64'(lat), 64'd4);
        check("wrap_sum", {32'd0, bus.sum}, 64'h0);
`ifdef ADDER_SEQ_CARRY_OUT_EN
        check("wrap_cout", {63'd0, bus.cout}, 64'd1);
`endif
        bus.out_ready = 1'b1;
        tick();
        check("wrap_handoff_valid", {63'd0, bus.out_valid}, 64'd0);
        check("wrap_handoff_ready", {63'd0, bus.in_ready}, 64'd1);
        check("wrap_handoff_busy", {63'd0, bus.busy}, 64'd0);
        bus.out_ready = 1'b0;

        // Carry chaining; busy must stay high through DONE until hand-off
        accept32(32'h00FF_00FF, 32'h0001_0001, 1'b1, acc);
        wait_out32(lat);
        check("chain_latency", 64'(lat), 64'd4);
        check("chain_sum", {32'd0, bus.sum}, 64'h0100_0101);
`ifdef ADDER_SEQ_CARRY_OUT_EN
        check("chain_cout", {63'd0, bus.cout}, 64'd0);
`endif
        tick();
        check("chain_busy_done", {63'd0, bus.busy}, 64'd1);
        bus.out_ready = 1'b1;
        tick();
        check("chain_busy_after", {63'd0, bus.busy}, 64'd0);
        bus.out_ready = 1'b0;

        // Back-pressure with a competing producer held on the input
        accept32(32'h1234_5678, 32'h1111_1111, 1'b0, acc);
        wait_out32(lat);
        check("bp_latency", 64'(lat), 64'd4);
        for (int i = 0; i < 10; i++) begin
            bus.in_valid = 1'b1;
            bus.a = $urandom;
            bus.b = $urandom;
            check("bp_out_valid", {63'd0, bus.out_valid}, 64'd1);
            check("bp_sum", {32'd0, bus.sum}, 64'h2345_6789);
            check("bp_in_ready", {63'd0, bus.in_ready}, 64'd0);
            tick();
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        check("bp_handoff_valid", {63'd0, bus.out_valid}, 64'd0);
        check("bp_handoff_ready", {63'd0, bus.in_ready}, 64'd1);
        bus.out_ready = 1'b0;

        // Reset two cycles into RUN
        accept32(32'h0101_0101, 32'h0101_0101, 1'b1, acc);
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check("mid_rst_in_ready", {63'd0, bus.in_ready}, 64'd1);
        check("mid_rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
        check("mid_rst_busy", {63'd0, bus.busy}, 64'd0);
        check("mid_rst_sum", {32'd0, bus.sum}, 64'd0);
`ifdef ADDER_SEQ_CARRY_OUT_EN
        check("mid_rst_cout", {63'd0, bus.cout}, 64'd0);
`endif
        #3;
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            check("post_rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
            check("post_rst_in_ready", {63'd0, bus.in_ready}, 64'd1);
        end

        // Back-to-back random operations with out_ready held high
        bus.out_ready = 1'b1;
        prev = 0;
        for (int i = 0; i < 10; i++) begin
            x = $urandom;
            y = $urandom;
            c = 1'($urandom_range(0, 1));
            e = ref_add32(x, y, c);
            accept32(x, y, c, acc);
            if (i > 0) check("b2b_spacing", 64'(acc - prev), 64'd6);
            prev = acc;
            wait_out32(lat);
            check("b2b_latency", 64'(lat), 64'd4);
            check("b2b_sum", {32'd0, bus.sum}, {32'd0, e[W-1:0]});
`ifdef ADDER_SEQ_CARRY_OUT_EN
            check("b2b_cout", {63'd0, bus.cout}, {63'd0, e[W]});
`endif
        end
        tick();
        bus.out_ready = 1'b0;

        // Degenerate width: one slice, RUN lasts one cycle
        for (int i = 0; i < 6; i++) begin
            if (i == 0) begin
                x8 = 8'h80; y8 = 8'h80; c = 1'b0;
            end else begin
                x8 = 8'($urandom); y8 = 8'($urandom); c = 1'($urandom_range(0, 1));
            end
            e8 = {1'b0, x8} + {1'b0, y8} + {8'd0, c};
            bus8.a = x8; bus8.b = y8; bus8.cin = c; bus8.in_valid = 1'b1;
            check("w8_in_ready", {63'd0, bus8.in_ready}, 64'd1);
            tick();
            bus8.in_valid = 1'b0;
            bus8.a = 8'($urandom); bus8.b = 8'($urandom);
            check("w8_busy", {63'd0, bus8.busy}, 64'd1);
            check("w8_valid_early", {63'd0, bus8.out_valid}, 64'd0);
            tick();
            check("w8_out_valid", {63'd0, bus8.out_valid}, 64'd1);
            check("w8_sum", {56'd0, bus8.sum}, {56'd0, e8[W8-1:0]});
`ifdef ADDER_SEQ_CARRY_OUT_EN
            check("w8_cout", {63'd0, bus8.cout}, {63'd0, e8[W8]});
`endif
            bus8.out_ready = 1'b1;
            tick();
            bus8.out_ready = 1'b0;
            check("w8_handoff_ready", {63'd0, bus8.in_ready}, 64'd1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
